// File: rtl/reset_sequencer.sv
// Staged reset release: hold all domains, free peripherals, then core.
// Ports: clock/reset, sw/wdog/ndm requests in; periph/core rst, done, cause out.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_sw_rst_req,
  input  logic       io_wdog_rst_req,
  input  logic       io_ndm_rst_req,
  output logic       io_periph_rst,
  output logic       io_core_rst,
  output logic       io_rst_done,
  output logic [1:0] io_rst_cause
);

  typedef enum logic [1:0] {
    ASSERT     = 2'd0,
    REL_PERIPH = 2'd1,
    RUN        = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] C_WDOG = 2'd1;
  localparam logic [1:0] C_SW   = 2'd2;
  localparam logic [1:0] C_NDM  = 2'd3;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [1:0]       cause, cause_n;
  logic             req;

  assign req = io_sw_rst_req
             | io_wdog_rst_req
             | io_ndm_rst_req;

  assign cnt_inc = (cnt == CNT_MAX)
                 ? cnt : cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ASSERT;
      cnt   <= '0;
      cause <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cause <= cause_n;
    end
  end

  // A request overrides every state and
  // restarts the hold count from zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cause_n = cause;
    if (req) begin
      state_n = ASSERT;
      cnt_n   = '0;
      unique case (1'b1)
        io_wdog_rst_req:
          cause_n = C_WDOG;
        !io_wdog_rst_req && io_ndm_rst_req:
          cause_n = C_NDM;
        default:
          cause_n = C_SW;
      endcase
    end else begin
      unique case (state)
        ASSERT: begin
          if (cnt == HOLD_LAST) begin
            state_n = REL_PERIPH;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        REL_PERIPH: begin
          if (cnt == GAP_LAST) begin
            state_n = RUN;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        RUN: begin
          state_n = RUN;
        end
        default: begin
          state_n = ASSERT;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    io_periph_rst = 1'b1;
    io_core_rst   = 1'b1;
    io_rst_done   = 1'b0;
    unique case (state)
      ASSERT: begin
        io_periph_rst = 1'b1;
      end
      REL_PERIPH: begin
        io_periph_rst = 1'b0;
      end
      RUN: begin
        io_periph_rst = 1'b0;
        io_core_rst   = 1'b0;
        io_rst_done   = 1'b1;
      end
      default: begin
        io_periph_rst = 1'b1;
      end
    endcase
  end

  assign io_rst_cause = cause;

endmodule
